generation_sequencer: RTL and testbench

// Upstream control stage for data_path. Sweeps every cell of the W x H toroidal grid once per generation, one cell per cycle.

---
 rtl/generation_sequencer_pkg.sv | 16 +
 rtl/generation_sequencer_axis_walker.sv | 58 +++++
 rtl/generation_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_generation_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/generation_sequencer_pkg.sv
// Shared constants and FSM state type for the generation sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package generation_sequencer_pkg;

    localparam int PIXELS_PER_BLOCK = 3;
    localparam int NUM_BANKS        = PIXELS_PER_BLOCK * PIXELS_PER_BLOCK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

endpackage

// File: rtl/generation_sequencer_axis_walker.sv
// One grid axis: sub-pixel (0..2) and block counters, with torus wrap.
// Latency: counters step on the clock edge where advance is high; neighbour outputs are combinational.
// Backpressure: none; advance is a plain enable from the owning FSM.
//
// Ports:
//   clk, resetn   clock, async active-low reset
//   advance       step to the next pixel along this axis
//   sub, blk      current pixel = PIXELS_PER_BLOCK*blk_index + sub; blk is pre-scaled by BLK_STEP
//   wrap          current pixel is the last one on the axis (advance would return to 0)
//   col_blk[s]    scaled block index of the neighbour (offset -1/0/+1) whose sub equals s
module generation_sequencer_axis_walker #(
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_BLKS   = 2,
    parameter int BLK_STEP   = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      advance,
    output logic [1:0]                sub,
    output logic [ADDR_WIDTH-1:0]     blk,
    output logic                      wrap,
    output logic [2:0][ADDR_WIDTH-1:0] col_blk
);

    // The block counter moves in steps of BLK_STEP so the row axis directly
    // yields the row base address (block_row * WIDTH_BLOCKS) without a multiplier.
    localparam logic [ADDR_WIDTH-1:0] LAST_BLK = ADDR_WIDTH'((NUM_BLKS - 1) * BLK_STEP);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BLK_STEP);

    logic [ADDR_WIDTH-1:0] blk_prev;
    logic [ADDR_WIDTH-1:0] blk_next;

    always_comb begin
        blk_prev = (blk == '0)       ? LAST_BLK : blk - STEP;
        blk_next = (blk == LAST_BLK) ? '0       : blk + STEP;
        wrap     = (sub == 2'd2) && (blk == LAST_BLK);
        // Only the -1 neighbour at sub=0 and the +1 neighbour at sub=2 leave
        // the current block; every other neighbour column shares it.
        col_blk[0] = (sub == 2'd2) ? blk_next : blk;
        col_blk[1] = blk;
        col_blk[2] = (sub == 2'd0) ? blk_prev : blk;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sub <= 2'd0;
            blk <= '0;
        end else if (advance) begin
            if (sub == 2'd2) begin
                sub <= 2'd0;
                blk <= blk_next;
            end else begin
                sub <= sub + 2'd1;
            end
        end
    end

endmodule

// File: rtl/generation_sequencer.sv
// Sweeps the banked toroidal grid one cell per cycle, driving 9-bank read addresses and a delayed write.
// Latency: reads for a cell appear the cycle after issue, its write one cycle later; start to done = W*H+2 cycles.
// Backpressure: none; start is only honoured in IDLE and is otherwise dropped.
//
// Ports:
//   clk, resetn              clock, async active-low reset
//   start                    request one generation (IDLE only)
//   busy, done               busy from accepted start until done; done is a one-cycle pulse
//   generation               count of completed generations
//   read_enable, read_addr_* per-bank read strobes and addresses for the 3x3 neighbourhood
//   write_enable, write_addr one-hot centre bank and its address, one cycle behind the reads
//   frame_buffer_select      toggled once per completed generation
module generation_sequencer
    import generation_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = 2,
    parameter int WIDTH_BLOCKS  = 2,
    parameter int HEIGHT_BLOCKS = 2,
    parameter int GEN_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [GEN_WIDTH-1:0]  generation,
    output logic [NUM_BANKS-1:0]  read_enable,
    output logic [ADDR_WIDTH-1:0] read_addr_0,
    output logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [ADDR_WIDTH-1:0] read_addr_3,
    output logic [ADDR_WIDTH-1:0] read_addr_4,
    output logic [ADDR_WIDTH-1:0] read_addr_5,
    output logic [ADDR_WIDTH-1:0] read_addr_6,
    output logic [ADDR_WIDTH-1:0] read_addr_7,
    output logic [ADDR_WIDTH-1:0] read_addr_8,
    output logic [NUM_BANKS-1:0]  write_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  frame_buffer_select
);

    state_t state_q;
    logic   last_q;     // final cell of the sweep has been issued

    logic [1:0]                    x_sub, y_sub;
    logic [ADDR_WIDTH-1:0]         x_blk, y_base;
    logic                          x_wrap, y_wrap;
    logic [2:0][ADDR_WIDTH-1:0]    x_col, y_col;

    logic                          issue;
    logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] nb_addr;
    logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] rd_addr_q;
    logic [3:0]                    centre_idx;
    logic [NUM_BANKS-1:0]          centre_oh;
    logic [ADDR_WIDTH-1:0]         centre_addr;

    // Centre cell of the previously issued read, held until its write slot.
    logic [NUM_BANKS-1:0]          pend_we;
    logic [ADDR_WIDTH-1:0]         pend_addr;

    always_comb begin
        issue = ((state_q == ST_IDLE) && start) || ((state_q == ST_RUN) && !last_q);
    end

    generation_sequencer_axis_walker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BLKS   (WIDTH_BLOCKS),
        .BLK_STEP   (1)
    ) u_x_walker (
        .clk     (clk),
        .resetn  (resetn),
        .advance (issue),
        .sub     (x_sub),
        .blk     (x_blk),
        .wrap    (x_wrap),
        .col_blk (x_col)
    );

    // Row axis counts in units of WIDTH_BLOCKS, so its block value is the row base address.
    generation_sequencer_axis_walker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BLKS   (HEIGHT_BLOCKS),
        .BLK_STEP   (WIDTH_BLOCKS)
    ) u_y_walker (
        .clk     (clk),
        .resetn  (resetn),
        .advance (issue && x_wrap),
        .sub     (y_sub),
        .blk     (y_base),
        .wrap    (y_wrap),
        .col_blk (y_col)
    );

    // Bank (sy,sx) holds exactly one pixel of the 3x3 neighbourhood: the one
    // whose row sub is sy and column sub is sx.
    for (genvar sy = 0; sy < 3; sy++) begin : g_row
        for (genvar sx = 0; sx < 3; sx++) begin : g_col
            assign nb_addr[sy*3+sx] = y_col[sy] + x_col[sx];
        end
    end

    always_comb begin
        centre_idx  = {2'b00, y_sub} + {2'b00, y_sub} + {2'b00, y_sub} + {2'b00, x_sub};
        centre_oh   = NUM_BANKS'(1) << centre_idx;
        centre_addr = y_base + x_blk;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q             <= ST_IDLE;
            last_q              <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            generation          <= '0;
            read_enable         <= '0;
            rd_addr_q           <= '0;
            pend_we             <= '0;
            pend_addr           <= '0;
            write_enable        <= '0;
            write_addr          <= '0;
            frame_buffer_select <= 1'b0;
        end else begin
            done         <= 1'b0;
            write_enable <= pend_we;
            write_addr   <= pend_addr;

            if (issue) begin
                read_enable <= '1;
                rd_addr_q   <= nb_addr;
                pend_we     <= centre_oh;
                pend_addr   <= centre_addr;
                last_q      <= x_wrap && y_wrap;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_q) begin
                        // DRAIN: reads stop, the last pending write goes out this edge.
                        state_q     <= ST_DRAIN;
                        last_q      <= 1'b0;
                        read_enable <= '0;
                        rd_addr_q   <= '0;
                        pend_we     <= '0;
                        pend_addr   <= '0;
                    end
                end
                ST_DRAIN: begin
                    state_q             <= ST_SWAP;
                    busy                <= 1'b0;
                    done                <= 1'b1;
                    frame_buffer_select <= ~frame_buffer_select;
                    generation          <= generation + GEN_WIDTH'(1);
                end
                ST_SWAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_addr_0 = rd_addr_q[0];
    assign read_addr_1 = rd_addr_q[1];
    assign read_addr_2 = rd_addr_q[2];
    assign read_addr_3 = rd_addr_q[3];
    assign read_addr_4 = rd_addr_q[4];
    assign read_addr_5 = rd_addr_q[5];
    assign read_addr_6 = rd_addr_q[6];
    assign read_addr_7 = rd_addr_q[7];
    assign read_addr_8 = rd_addr_q[8];

endmodule

// File: tb/tb_generation_sequencer.sv
// Self-checking bench: pixel-level reference model plus a table of hand-derived cells.
// Latency: n/a.
// Backpressure: n/a.
module tb_generation_sequencer;

    localparam int AW    = 2;
    localparam int WB    = 2;
    localparam int HB    = 2;
    localparam int GW    = 16;
    localparam int WP    = 3 * WB;
    localparam int HP    = 3 * HB;
    localparam int CELLS = WP * HP;
    localparam int LAST  = CELLS + 2;   // cycle index of the SWAP/done cycle

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fbs;
    logic [GW-1:0] generation;
    logic [8:0]    read_enable, write_enable;
    logic [8:0][AW-1:0] ra;
    logic [AW-1:0] write_addr;

    generation_sequencer #(
        .ADDR_WIDTH(AW), .WIDTH_BLOCKS(WB), .HEIGHT_BLOCKS(HB), .GEN_WIDTH(GW)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .busy(busy), .done(done), .generation(generation),
        .read_enable(read_enable),
        .read_addr_0(ra[0]), .read_addr_1(ra[1]), .read_addr_2(ra[2]),
        .read_addr_3(ra[3]), .read_addr_4(ra[4]), .read_addr_5(ra[5]),
        .read_addr_6(ra[6]), .read_addr_7(ra[7]), .read_addr_8(ra[8]),
        .write_enable(write_enable), .write_addr(write_addr),
        .frame_buffer_select(fbs)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_gen = 0;
    logic exp_fbs = 1'b0;

    typedef struct packed {
        logic [2:0]         x;
        logic [2:0]         y;
        logic [8:0][AW-1:0] ra;
        logic [8:0]         we;
        logic [AW-1:0]      wa;
    } vec_t;

    vec_t tbl[5];

    function automatic vec_t mk(input int x, input int y,
                                input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5,
                                input int a6, input int a7, input int a8,
                                input int we, input int wa);
        vec_t v;
        v.x = 3'(x); v.y = 3'(y);
        v.ra[0] = AW'(a0); v.ra[1] = AW'(a1); v.ra[2] = AW'(a2);
        v.ra[3] = AW'(a3); v.ra[4] = AW'(a4); v.ra[5] = AW'(a5);
        v.ra[6] = AW'(a6); v.ra[7] = AW'(a7); v.ra[8] = AW'(a8);
        v.we = 9'(we); v.wa = AW'(wa);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model in pixel coordinates.
    function automatic int bank_of(input int px, input int py);
        return (py % 3) * 3 + (px % 3);
    endfunction

    function automatic int addr_of(input int px, input int py);
        return (py / 3) * WB + (px / 3);
    endfunction

    int m_ra[9];

    function automatic void model_reads(input int c);
        int x, y, nx, ny;
        x = c % WP;
        y = c / WP;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = (x + dx + WP) % WP;
                ny = (y + dy + HP) % HP;
                m_ra[bank_of(nx, ny)] = addr_of(nx, ny);
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " generation"}, 32'(generation), 0);
        check({tag, " read_enable"}, 32'(read_enable), 0);
        for (int b = 0; b < 9; b++)
            check($sformatf("%s read_addr_%0d", tag, b), 32'(ra[b]), 0);
        check({tag, " write_enable"}, 32'(write_enable), 0);
        check({tag, " write_addr"}, 32'(write_addr), 0);
        check({tag, " fbs"}, 32'(fbs), 0);
    endtask

    // One full generation, checked every cycle. inject: spurious start pulses
    // during RUN/DRAIN and in the SWAP cycle. hold: start stays high from the
    // SWAP cycle into IDLE so the next call's start is accepted one cycle later.
    task automatic run_gen(input bit inject, input bit hold);
        int wcnt[9][4];
        int c, ewe, ewa;
        for (int b = 0; b < 9; b++)
            for (int a = 0; a < 4; a++)
                wcnt[b][a] = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= LAST; n++) begin
            if (n == LAST) begin
                exp_fbs = ~exp_fbs;
                exp_gen = (exp_gen + 1) % (1 << GW);
            end
            check($sformatf("busy n=%0d", n), 32'(busy), 32'(n < LAST));
            check($sformatf("done n=%0d", n), 32'(done), 32'(n == LAST));
            check($sformatf("read_enable n=%0d", n), 32'(read_enable), (n <= CELLS) ? 32'h1FF : 0);
            if (n <= CELLS) begin
                model_reads(n - 1);
                for (int b = 0; b < 9; b++)
                    check($sformatf("read_addr_%0d cell %0d", b, n - 1), 32'(ra[b]), 32'(m_ra[b]));
            end
            ewe = 0;
            ewa = 0;
            if (n >= 2 && n <= CELLS + 1) begin
                c = n - 2;
                ewe = 1 << bank_of(c % WP, c / WP);
                ewa = addr_of(c % WP, c / WP);
            end
            check($sformatf("write_enable n=%0d", n), 32'(write_enable), 32'(ewe));
            check($sformatf("write_addr n=%0d", n), 32'(write_addr), 32'(ewa));
            for (int b = 0; b < 9; b++)
                if (write_enable[b]) wcnt[b][write_addr]++;
            for (int t = 0; t < 5; t++) begin
                if (int'(tbl[t].y) * WP + int'(tbl[t].x) == n - 1)
                    for (int b = 0; b < 9; b++)
                        check($sformatf("tbl%0d read_addr_%0d", t, b), 32'(ra[b]), 32'(tbl[t].ra[b]));
                if (int'(tbl[t].y) * WP + int'(tbl[t].x) == n - 2) begin
                    check($sformatf("tbl%0d write_enable", t), 32'(write_enable), 32'(tbl[t].we));
                    check($sformatf("tbl%0d write_addr", t), 32'(write_addr), 32'(tbl[t].wa));
                end
            end
            check($sformatf("fbs n=%0d", n), 32'(fbs), 32'(exp_fbs));
            check($sformatf("generation n=%0d", n), 32'(generation), 32'(exp_gen));
            if (n < LAST) start = inject && ($urandom_range(0, 5) == 0);
            else          start = inject || hold;
            @(negedge clk);
        end
        for (int b = 0; b < 9; b++)
            for (int a = 0; a < WB * HB; a++)
                check($sformatf("written once bank %0d addr %0d", b, a), 32'(wcnt[b][a]), 1);
        if (!hold) begin
            start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                check("idle busy", 32'(busy), 0);
                check("idle done", 32'(done), 0);
                check("idle read_enable", 32'(read_enable), 0);
                check("idle generation", 32'(generation), 32'(exp_gen));
                @(negedge clk);
            end
        end
    endtask

    task automatic reset_mid_run();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        model_reads(10);
        check("mid-run busy", 32'(busy), 1);
        check("mid-run cell10 read_addr_4", 32'(ra[4]), 32'(m_ra[4]));
        resetn = 1'b0;
        #1;
        check_all_zero("mid-run reset");
        exp_fbs = 1'b0;
        exp_gen = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_all_zero("after reset release");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values derived by hand from pixel (x,y) -> bank (y%3)*3+(x%3), addr (y/3)*2+(x/3).
        tbl[0] = mk(0, 0, 0, 0, 1, 0, 0, 1, 2, 2, 3, 9'h001, 0);
        tbl[1] = mk(3, 3, 3, 3, 2, 3, 3, 2, 1, 1, 0, 9'h001, 3);
        tbl[2] = mk(5, 5, 0, 1, 1, 2, 3, 3, 2, 3, 3, 9'h100, 3);
        tbl[3] = mk(1, 4, 2, 2, 2, 2, 2, 2, 2, 2, 2, 9'h010, 2);
        tbl[4] = mk(2, 0, 1, 0, 0, 1, 0, 0, 3, 2, 2, 9'h004, 0);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_all_zero("post-reset idle");

        run_gen(1'b0, 1'b0);    // fbs 0->1, generation 1
        run_gen(1'b1, 1'b0);    // spurious starts ignored; fbs back to 0, generation 2
        reset_mid_run();
        run_gen(1'b0, 1'b1);    // restart from (0,0); start held across SWAP into IDLE
        run_gen(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_gen(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        run_gen(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
